issue_queue_wakeup: RTL and testbench
=====================================

# issue_queue_wakeup

Parametrised issue queue that sits between decode/rename and the execute pipes. Decode no longer stalls on pending source operands: renamed micro-ops are enqueued with per-source pending bits and woken by completion broadcasts, and ready ops are selected for issue oldest-first. Entries are age-ordered in a collapsing array, where slot 0 is always the oldest valid entry.

## Interface
Parameters:
- p_depth, 4: number of queue entries (≥2)
- p_num_phys_regs, 36: physical register count; p_phys_addr_bits = $clog2(p_num_phys_regs)
- p_payload_bits, 64: opaque payload width (uop, seq_num, pc, etc.)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enq_val  in  1  decode offers an op
- enq_rdy  out  1  queue accepts this cycle
- enq_payload  in  p_payload_bits  op payload
- enq_psrc0, enq_psrc1  in  p_phys_addr_bits each  source pregs
- enq_pend0, enq_pend1  in  1 each  source not yet produced
- wake_val  in  1  completion broadcast valid
- wake_preg  in  p_phys_addr_bits  produced preg
- deq_val  out  1  an op is ready to issue
- deq_rdy  in  1  execute accepts
- deq_payload  out  p_payload_bits  selected op payload
- flush  in  1  squash all entries
- count  out  $clog2(p_depth+1)  valid entries

## Operation
- Per entry: val, payload, psrc0/1, pend0/1. An entry is ready when val and !pend0 and !pend1.
- Select: deq_val = some entry is eligible. The eligible entry is the lowest-index ready entry, or slot 0 only (see Configuration). deq_payload is that entry's payload. deq_payload is don't-care when deq_val=0.
- Dequeue when deq_val & deq_rdy. Entries above the selected slot shift down by one, preserving order.
- Enqueue when enq_val & enq_rdy. The op is written into the first free slot after any same-cycle shift, i.e. index count − (dequeue ? 1 : 0).
- enq_rdy = !flush & (count < p_depth). It depends on registered count only. When full, a same-cycle dequeue does not free space until the next cycle.
- Wakeup: when wake_val, every valid entry with psrcN == wake_preg clears pendN. This includes entries that shift in the same cycle.
- Enqueue/wakeup bypass: if wake_val and wake_preg == enq_psrcN, the enqueued pendN is written as 0.
- A wake_preg that matches no entry is ignored. Multiple matching entries all clear.
- Flush: all val cleared next cycle and count=0. Flush overrides enqueue, dequeue, and wakeup that cycle. deq_val is unaffected in the flush cycle (combinational from state), but deq_rdy handshakes in that cycle are discarded by the bench.
- Reset: all val=0 and count=0. Hence deq_val=0 and enq_rdy=1 after reset. Payload, psrc, and pend reset to don't-care.

## Timing
- Enqueue to earliest issue: 1 cycle (the op is visible in state next cycle if both sources are ready or bypassed).
- Wakeup to issue of a dependent entry: 1 cycle.
- deq_val, deq_payload, enq_rdy, and count are functions of registered state. The only exception is that enq_rdy is gated by flush.
- Simultaneous enqueue + dequeue when count<p_depth: count unchanged.
- Full + dequeue: count becomes p_depth−1 and enq_rdy rises next cycle.
- Empty + enqueue: count becomes 1. deq_val does not assert in the same cycle (no pass-through).
- Reset asserted mid-operation: state is cleared the next edge regardless of other inputs.

## Configuration
- ISSUE_QUEUE_OOO_EN defined: out-of-order select, i.e. the oldest ready entry at any index.
- ISSUE_QUEUE_OOO_EN undefined: in-order select.
  - Only slot 0 is eligible.
  - deq_val = slot0 ready.
  - A younger ready entry waits behind a pending slot 0.
- Wakeup, bypass, and flush are identical in both builds.

## Test plan
- Basic flow: enqueue A (psrc 3/4, both ready), deq_rdy=1. Required: deq_val=1 the next cycle with payload A; count goes 1 then 0.
- Wakeup:
  - Enqueue B with pend0=1, psrc0=7. deq_val stays 0.
  - Drive wake_val=1, wake_preg=7. Required: deq_val=1 the next cycle with payload B.
- Bypass: enqueue C (psrc1=9, pend1=1) in the same cycle as wake_preg=9. Required: deq_val=1 next cycle.
- Ordering:
  - Enqueue D (pending on 5), then E (ready).
  - With the macro defined: E issues first, then D after wake 5.
  - Without the macro: nothing issues until wake 5, then D followed by E.
- Full/backpressure (p_depth=4):
  - Fill 4 ready entries with deq_rdy=0. Required: enq_rdy=0 and count=4.
  - Set deq_rdy=1 for one cycle. Required: enq_rdy=1 the next cycle and count=3; remaining entries keep their order.
- Flush/reset: with 3 entries, assert flush together with enq_val=1. Required: next cycle count=0, deq_val=0, and the enqueued op is dropped. Repeat with rst instead of flush; the same result is required.

Source files
------------

// File: rtl/issue_queue_wakeup_if.sv
// Issue queue handshake bundle.
//   master: decode/wakeup/execute side (drives enq_*, wake_*, deq_rdy, flush)
//   slave : the issue queue (drives enq_rdy, deq_val, deq_payload, count)
interface issue_queue_wakeup_if #(
  parameter int unsigned p_depth         = 4,
  parameter int unsigned p_num_phys_regs = 36,
  parameter int unsigned p_payload_bits  = 64
);
  localparam int unsigned p_phys_addr_bits = $clog2(p_num_phys_regs);
  localparam int unsigned p_count_bits     = $clog2(p_depth + 1);

  logic                        enq_val;
  logic                        enq_rdy;
  logic [p_payload_bits-1:0]   enq_payload;
  logic [p_phys_addr_bits-1:0] enq_psrc0;
  logic [p_phys_addr_bits-1:0] enq_psrc1;
  logic                        enq_pend0;
  logic                        enq_pend1;
  logic                        wake_val;
  logic [p_phys_addr_bits-1:0] wake_preg;
  logic                        deq_val;
  logic                        deq_rdy;
  logic [p_payload_bits-1:0]   deq_payload;
  logic                        flush;
  logic [p_count_bits-1:0]     count;

  modport master (
    output enq_val, enq_payload, enq_psrc0, enq_psrc1, enq_pend0, enq_pend1,
    output wake_val, wake_preg, deq_rdy, flush,
    input  enq_rdy, deq_val, deq_payload, count
  );

  modport slave (
    input  enq_val, enq_payload, enq_psrc0, enq_psrc1, enq_pend0, enq_pend1,
    input  wake_val, wake_preg, deq_rdy, flush,
    output enq_rdy, deq_val, deq_payload, count
  );
endinterface

// File: rtl/issue_queue_wakeup.sv
// Age-ordered collapsing issue queue with operand wakeup.
// Slot 0 always holds the oldest valid entry. Ops enter with per-source
// pending bits that are cleared by completion broadcasts (wake_val/wake_preg),
// including a same-cycle bypass for the op being enqueued.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   q   - issue_queue_wakeup_if.slave (enqueue, wakeup, dequeue, flush, count)
// Build option:
//   ISSUE_QUEUE_OOO_EN defined  : oldest ready entry at any slot may issue
//   ISSUE_QUEUE_OOO_EN undefined: only slot 0 may issue (in-order)
module issue_queue_wakeup #(
  parameter int unsigned p_depth         = 4,
  parameter int unsigned p_num_phys_regs = 36,
  parameter int unsigned p_payload_bits  = 64
) (
  input logic              clk,
  input logic              rst,
  issue_queue_wakeup_if.slave q
);
  localparam int unsigned AW = $clog2(p_num_phys_regs);
  localparam int unsigned CW = $clog2(p_depth + 1);
  localparam int unsigned IW = $clog2(p_depth);

  logic                      val_q     [p_depth];
  logic [p_payload_bits-1:0] payload_q [p_depth];
  logic [AW-1:0]             psrc0_q   [p_depth];
  logic [AW-1:0]             psrc1_q   [p_depth];
  logic                      pend0_q   [p_depth];
  logic                      pend1_q   [p_depth];
  logic [CW-1:0]             count_q;

  logic                      val_d     [p_depth];
  logic [p_payload_bits-1:0] payload_d [p_depth];
  logic [AW-1:0]             psrc0_d   [p_depth];
  logic [AW-1:0]             psrc1_d   [p_depth];
  logic                      pend0_d   [p_depth];
  logic                      pend1_d   [p_depth];
  logic [CW-1:0]             count_d;

  logic [p_depth-1:0] ready;
  logic [IW-1:0]      sel;
  logic               sel_val;
  logic               deq_fire;
  logic               enq_fire;
  logic [CW-1:0]      enq_idx;
  logic               byp0;
  logic               byp1;

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < p_depth; i++)
      ready[i] = val_q[i] & ~pend0_q[i] & ~pend1_q[i];
  end

  always_comb begin
    sel     = '0;
    sel_val = 1'b0;
`ifdef ISSUE_QUEUE_OOO_EN
    for (int unsigned i = 0; i < p_depth; i++) begin
      if (ready[i] && !sel_val) begin
        sel     = IW'(i);
        sel_val = 1'b1;
      end
    end
`else
    sel_val = ready[0];
`endif
  end

  assign q.deq_val     = sel_val;
  assign q.deq_payload = payload_q[sel];
  assign q.count       = count_q;
  assign q.enq_rdy     = ~q.flush & (count_q < CW'(p_depth));

  assign deq_fire = sel_val & q.deq_rdy;
  assign enq_fire = q.enq_val & q.enq_rdy;
  // Free slot after any same-cycle collapse.
  assign enq_idx  = count_q - CW'(deq_fire);
  assign byp0     = q.wake_val & (q.enq_psrc0 == q.wake_preg);
  assign byp1     = q.wake_val & (q.enq_psrc1 == q.wake_preg);

  always_comb begin
    val_d     = val_q;
    payload_d = payload_q;
    psrc0_d   = psrc0_q;
    psrc1_d   = psrc1_q;
    pend0_d   = pend0_q;
    pend1_d   = pend1_q;
    count_d   = count_q + CW'(enq_fire) - CW'(deq_fire);

    // Collapse: every slot at or above the selected one takes its upper
    // neighbour; the top slot is always vacated by a dequeue.
    if (deq_fire) begin
      for (int unsigned i = 0; i + 1 < p_depth; i++) begin
        if (IW'(i) >= sel) begin
          val_d[i]     = val_q[i+1];
          payload_d[i] = payload_q[i+1];
          psrc0_d[i]   = psrc0_q[i+1];
          psrc1_d[i]   = psrc1_q[i+1];
          pend0_d[i]   = pend0_q[i+1];
          pend1_d[i]   = pend1_q[i+1];
        end
      end
      val_d[p_depth-1] = 1'b0;
    end

    // Wakeup is applied to post-collapse contents so shifting entries
    // still see the broadcast.
    if (q.wake_val) begin
      for (int unsigned i = 0; i < p_depth; i++) begin
        if (psrc0_d[i] == q.wake_preg) pend0_d[i] = 1'b0;
        if (psrc1_d[i] == q.wake_preg) pend1_d[i] = 1'b0;
      end
    end

    if (enq_fire) begin
      for (int unsigned i = 0; i < p_depth; i++) begin
        if (CW'(i) == enq_idx) begin
          val_d[i]     = 1'b1;
          payload_d[i] = q.enq_payload;
          psrc0_d[i]   = q.enq_psrc0;
          psrc1_d[i]   = q.enq_psrc1;
          pend0_d[i]   = q.enq_pend0 & ~byp0;
          pend1_d[i]   = q.enq_pend1 & ~byp1;
        end
      end
    end

    if (q.flush) begin
      for (int unsigned i = 0; i < p_depth; i++) val_d[i] = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < p_depth; i++) val_q[i] <= 1'b0;
      count_q <= '0;
    end else begin
      val_q   <= val_d;
      count_q <= count_d;
    end
    payload_q <= payload_d;
    psrc0_q   <= psrc0_d;
    psrc1_q   <= psrc1_d;
    pend0_q   <= pend0_d;
    pend1_q   <= pend1_d;
  end
endmodule

// File: tb/tb_issue_queue_wakeup.sv
module tb_issue_queue_wakeup;
  localparam int unsigned D   = 4;
  localparam int unsigned NPR = 36;
  localparam int unsigned PB  = 64;
  localparam int unsigned AW  = $clog2(NPR);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_queue_wakeup_if #(.p_depth(D), .p_num_phys_regs(NPR), .p_payload_bits(PB)) qif ();

  issue_queue_wakeup #(.p_depth(D), .p_num_phys_regs(NPR), .p_payload_bits(PB)) dut (
    .clk(clk),
    .rst(rst),
    .q  (qif.slave)
  );

  typedef struct {
    logic [PB-1:0] pl;
    logic [AW-1:0] s0;
    logic [AW-1:0] s1;
    logic          p0;
    logic          p1;
  } ent_t;

  ent_t mq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Oldest entry allowed to issue under the build's select policy, -1 if none.
  function automatic int model_sel();
`ifdef ISSUE_QUEUE_OOO_EN
    foreach (mq[i]) if (!mq[i].p0 && !mq[i].p1) return i;
    return -1;
`else
    if (mq.size() > 0 && !mq[0].p0 && !mq[0].p1) return 0;
    return -1;
`endif
  endfunction

  // Check outputs against the model, clock once, advance the model.
  task automatic cycle();
    int   s;
    ent_t e;
    bit   ef;
    #1;
    s = model_sel();
    chk("count", 64'(qif.count), 64'(mq.size()));
    chk("enq_rdy", 64'(qif.enq_rdy), 64'(!qif.flush && mq.size() < D));
    chk("deq_val", 64'(qif.deq_val), 64'(s >= 0));
    if (s >= 0) chk("deq_payload", qif.deq_payload, mq[s].pl);
    @(posedge clk);
    if (rst || qif.flush) begin
      mq.delete();
    end else begin
      ef = qif.enq_val && (mq.size() < D);
      if (s >= 0 && qif.deq_rdy) mq.delete(s);
      if (qif.wake_val) begin
        foreach (mq[i]) begin
          if (mq[i].s0 == qif.wake_preg) mq[i].p0 = 1'b0;
          if (mq[i].s1 == qif.wake_preg) mq[i].p1 = 1'b0;
        end
      end
      if (ef) begin
        e.pl = qif.enq_payload;
        e.s0 = qif.enq_psrc0;
        e.s1 = qif.enq_psrc1;
        e.p0 = qif.enq_pend0 && !(qif.wake_val && qif.wake_preg == qif.enq_psrc0);
        e.p1 = qif.enq_pend1 && !(qif.wake_val && qif.wake_preg == qif.enq_psrc1);
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    rst             = 1'b0;
    qif.enq_val     = 1'b0;
    qif.enq_payload = '0;
    qif.enq_psrc0   = '0;
    qif.enq_psrc1   = '0;
    qif.enq_pend0   = 1'b0;
    qif.enq_pend1   = 1'b0;
    qif.wake_val    = 1'b0;
    qif.wake_preg   = '0;
    qif.flush       = 1'b0;
    qif.deq_rdy     = rdy;
  endtask

  task automatic enq(input logic [PB-1:0] pl, input int s0, input logic p0,
                     input int s1, input logic p1);
    qif.enq_val     = 1'b1;
    qif.enq_payload = pl;
    qif.enq_psrc0   = AW'(s0);
    qif.enq_pend0   = p0;
    qif.enq_psrc1   = AW'(s1);
    qif.enq_pend1   = p1;
  endtask

  task automatic wake(input int preg);
    qif.wake_val  = 1'b1;
    qif.wake_preg = AW'(preg);
  endtask

  initial begin
    idle(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    chk("rst_count", 64'(qif.count), 64'd0);
    chk("rst_deq_val", 64'(qif.deq_val), 64'd0);
    chk("rst_enq_rdy", 64'(qif.enq_rdy), 64'd1);

    // Basic flow
    idle(1'b1); enq(64'hA, 3, 1'b0, 4, 1'b0); cycle();
    idle(1'b1);
    chk("basic_count1", 64'(qif.count), 64'd1);
    chk("basic_deq_val", 64'(qif.deq_val), 64'd1);
    chk("basic_payload", qif.deq_payload, 64'hA);
    cycle();
    chk("basic_count0", 64'(qif.count), 64'd0);

    // Wakeup
    idle(1'b1); enq(64'hB, 7, 1'b1, 8, 1'b0); cycle();
    idle(1'b1);
    chk("wake_wait", 64'(qif.deq_val), 64'd0);
    wake(7); cycle();
    idle(1'b1);
    chk("wake_deq_val", 64'(qif.deq_val), 64'd1);
    chk("wake_payload", qif.deq_payload, 64'hB);
    cycle();

    // Enqueue/wakeup bypass
    idle(1'b1); enq(64'hC, 10, 1'b0, 9, 1'b1); wake(9); cycle();
    idle(1'b1);
    chk("byp_deq_val", 64'(qif.deq_val), 64'd1);
    chk("byp_payload", qif.deq_payload, 64'hC);
    cycle();

    // Ordering
    idle(1'b1); enq(64'hD, 5, 1'b1, 11, 1'b0); cycle();
    idle(1'b1); enq(64'hE, 12, 1'b0, 13, 1'b0); cycle();
    idle(1'b1);
`ifdef ISSUE_QUEUE_OOO_EN
    chk("ord_first", qif.deq_payload, 64'hE);
    cycle();
    chk("ord_blocked", 64'(qif.deq_val), 64'd0);
    wake(5); cycle();
    idle(1'b1);
    chk("ord_second", qif.deq_payload, 64'hD);
    cycle();
`else
    chk("ord_blocked", 64'(qif.deq_val), 64'd0);
    wake(5); cycle();
    idle(1'b1);
    chk("ord_first", qif.deq_payload, 64'hD);
    cycle();
    chk("ord_second", qif.deq_payload, 64'hE);
    cycle();
`endif
    chk("ord_empty", 64'(qif.count), 64'd0);

    // Full / backpressure
    for (int k = 0; k < 4; k++) begin
      idle(1'b0); enq(64'hF0 + 64'(k), 1, 1'b0, 2, 1'b0); cycle();
    end
    idle(1'b0);
    chk("full_enq_rdy", 64'(qif.enq_rdy), 64'd0);
    chk("full_count", 64'(qif.count), 64'd4);
    idle(1'b1); enq(64'hBAD, 1, 1'b0, 2, 1'b0); cycle();
    idle(1'b0);
    chk("full_deq_count", 64'(qif.count), 64'd3);
    chk("full_deq_enq_rdy", 64'(qif.enq_rdy), 64'd1);
    chk("full_deq_order", qif.deq_payload, 64'hF1);

    // Flush with concurrent enqueue
    idle(1'b1); enq(64'hDEAD, 1, 1'b0, 2, 1'b0); qif.flush = 1'b1; cycle();
    idle(1'b0);
    chk("flush_count", 64'(qif.count), 64'd0);
    chk("flush_deq_val", 64'(qif.deq_val), 64'd0);

    // Reset with concurrent enqueue
    for (int k = 0; k < 3; k++) begin
      idle(1'b0); enq(64'h70 + 64'(k), 1, 1'b0, 2, 1'b0); cycle();
    end
    idle(1'b1); enq(64'hBEEF, 1, 1'b0, 2, 1'b0); rst = 1'b1; cycle();
    idle(1'b0);
    chk("rst2_count", 64'(qif.count), 64'd0);
    chk("rst2_deq_val", 64'(qif.deq_val), 64'd0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      idle($urandom_range(99) < 60);
      if ($urandom_range(99) < 70)
        enq({$urandom, $urandom}, int'($urandom_range(7)), 1'($urandom),
            int'($urandom_range(7)), 1'($urandom));
      if ($urandom_range(99) < 50) wake(int'($urandom_range(7)));
      qif.flush = ($urandom_range(99) < 2);
      rst       = ($urandom_range(99) < 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
